// File: rtl/scfifo_drain_pkg.sv
// Shared types and constants for the show-ahead FIFO burst drain block.
package scfifo_drain_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } drain_state_e;

   localparam int BCNT_W = 16;

endpackage

// File: rtl/drain_out_buf.sv
// Two-entry in-order buffer with push/pop and head outputs; usable as a skid stage.
module drain_out_buf
   import scfifo_drain_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   occ,
   output logic         head_valid,
   output logic [W-1:0] head_data
);

   logic [W-1:0] e0_q;
   logic [W-1:0] e1_q;
   logic [1:0]   cnt_q;
   logic         pop_ok;
   logic         push_ok;

   // A push into a full buffer is only accepted when the head leaves the same cycle.
   assign pop_ok  = pop && (cnt_q != 2'd0);
   assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (cnt_q == 2'd0) e0_q <= push_data;
               else               e1_q <= push_data;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               e0_q  <= e1_q;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  e0_q <= push_data;
               end else begin
                  e0_q <= e1_q;
                  e1_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign occ        = cnt_q;
   assign head_valid = (cnt_q != 2'd0);
   assign head_data  = e0_q;

endmodule

// File: rtl/scfifo_burst_drain.sv
// Drains a show-ahead FIFO as fixed-length bursts onto a valid/ready stream with m_last.
// Optional partial-burst flush after an idle timeout: define SCFIFO_DRAIN_FLUSH_EN.
module scfifo_burst_drain
   import scfifo_drain_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 10,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DW-1:0]     fifo_dout,
   input  logic              fifo_empty,
   input  logic [AW-1:0]     fifo_data_cnt,
   output logic              fifo_read,
   output logic [DW-1:0]     m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic [BCNT_W-1:0] bursts_done
);

   if (BURST_LEN < 1 || BURST_LEN > (2**AW) - 1) begin : g_bad_burst_len
      $error("scfifo_burst_drain: BURST_LEN out of range 1..2**AW-1");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("scfifo_burst_drain: TIMEOUT out of range 1..65535");
   end

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } drain_entry_t;

   localparam logic [AW-1:0] BLEN_C = AW'(BURST_LEN);

   drain_state_e      state_q;
   drain_state_e      state_d;
   logic [AW-1:0]     beat_q;
   logic [AW-1:0]     blen_q;
   logic [BCNT_W-1:0] bursts_q;
   logic              start_go;
   logic [AW-1:0]     start_len;
   logic              last_rd;
   logic [1:0]        occ;
   logic              head_valid;
   drain_entry_t      push_e;
   drain_entry_t      head_e;

`ifdef SCFIFO_DRAIN_FLUSH_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] timer_q;
`endif

   // Read strobe looks only at registered state and FIFO flags, never at m_ready.
   always_comb begin
      state_d   = state_q;
      start_go  = 1'b0;
      start_len = BLEN_C;
      fifo_read = (state_q == BURST) && !fifo_empty && (occ != 2'd2);
      last_rd   = fifo_read && (beat_q == blen_q - AW'(1));
      case (state_q)
         IDLE: begin
            if (fifo_data_cnt >= BLEN_C) begin
               start_go = 1'b1;
               state_d  = BURST;
            end
`ifdef SCFIFO_DRAIN_FLUSH_EN
            else if (timer_q == TMO_LAST && !fifo_empty) begin
               start_go  = 1'b1;
               start_len = fifo_data_cnt;
               state_d   = BURST;
            end
`endif
         end
         BURST: begin
            if (last_rd) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         blen_q   <= '0;
         bursts_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_go) begin
            blen_q <= start_len;
            beat_q <= '0;
         end else if (fifo_read) begin
            beat_q <= beat_q + AW'(1);
         end
         if (last_rd) bursts_q <= bursts_q + BCNT_W'(1);
      end
   end

`ifdef SCFIFO_DRAIN_FLUSH_EN
   // Idle timer only runs while a partial burst sits in the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if (state_q != IDLE || fifo_empty || start_go) begin
         timer_q <= '0;
      end else if (fifo_data_cnt < BLEN_C) begin
         timer_q <= timer_q + 16'd1;
      end
   end
`endif

   assign push_e.data = fifo_dout;
   assign push_e.last = last_rd;

   drain_out_buf #(
      .W ($bits(drain_entry_t))
   ) u_out_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_read),
      .push_data  (push_e),
      .pop        (m_valid && m_ready),
      .occ        (occ),
      .head_valid (head_valid),
      .head_data  (head_e)
   );

   assign m_data      = head_e.data;
   assign m_valid     = head_valid;
   assign m_last      = head_valid && head_e.last;
   assign busy        = (state_q == BURST);
   assign bursts_done = bursts_q;

endmodule

// File: tb/tb_scfifo_burst_drain.sv
// Self-checking bench for scfifo_burst_drain with a queue-based FIFO and stream model.
module tb_scfifo_burst_drain;

   localparam int DW  = 8;
   localparam int AW  = 10;
   localparam int BL  = 4;
   localparam int TMO = 8;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic [AW-1:0] fifo_data_cnt;
   logic          fifo_read;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic          busy;
   logic [15:0]   bursts_done;

   ent_t          fifo_q[$];
   ent_t          out_q[$];
   int            checks = 0;
   int            errors = 0;
   int            wr_cnt = 0;
   int            rdy_mode = 0;
   logic [15:0]   exp_bursts = '0;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic          obs_rd, obs_acc, obs_valid, obs_last;
   logic [DW-1:0] obs_data;

   always #5 clk = ~clk;

   scfifo_burst_drain #(
      .DW        (DW),
      .AW        (AW),
      .BURST_LEN (BL),
      .TIMEOUT   (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_data_cnt (fifo_data_cnt),
      .fifo_read     (fifo_read),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_last        (m_last),
      .m_ready       (m_ready),
      .busy          (busy),
      .bursts_done   (bursts_done)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic drive_fifo();
      fifo_empty    = (fifo_q.size() == 0);
      fifo_dout     = fifo_empty ? '0 : fifo_q[0].data;
      fifo_data_cnt = AW'(fifo_q.size());
   endtask

   // Words are grouped into bursts by their position in the write stream.
   task automatic write_word(input logic [DW-1:0] d, input logic force_last);
      ent_t e;
      e.data = d;
      e.last = force_last || ((wr_cnt % BL) == BL - 1);
      fifo_q.push_back(e);
      wr_cnt = force_last ? 0 : (wr_cnt + 1) % BL;
      drive_fifo();
   endtask

   // One clock: observe at the falling edge, advance the models after the rising edge.
   task automatic tick();
      ent_t e;
      logic rd, acc;
      @(negedge clk);
      rd = fifo_read;
      acc = m_valid && m_ready;
      obs_rd = rd; obs_acc = acc; obs_valid = m_valid; obs_last = m_last; obs_data = m_data;
      checks++;
      if (m_valid !== (out_q.size() != 0)) begin
         errors++;
         $display("FAIL valid got %b want %b", m_valid, out_q.size() != 0);
      end
      if (acc && out_q.size() != 0) begin
         checks++;
         if ({m_last, m_data} !== out_q[0]) begin
            errors++;
            $display("FAIL stream_word got last=%b data=%h want last=%b data=%h",
                     m_last, m_data, out_q[0].last, out_q[0].data);
         end
      end
      checks++;
      if (bursts_done !== exp_bursts) begin
         errors++;
         $display("FAIL bursts_done got %0d want %0d", bursts_done, exp_bursts);
      end
      if (rd) begin
         checks++;
         if (fifo_q.size() == 0) begin
            errors++;
            $display("FAIL underflow got fifo_read=1 want 0 while empty");
         end
      end
      if (hold_prev) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== hold_data) begin
            errors++;
            $display("FAIL hold got v=%b d=%h want v=1 d=%h", m_valid, m_data, hold_data);
         end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      @(posedge clk);
      #1;
      if (acc && out_q.size() != 0) out_q.delete(0);
      if (rd && fifo_q.size() != 0) begin
         e = fifo_q.pop_front();
         out_q.push_back(e);
         if (e.last) exp_bursts++;
      end
      checks++;
      if (out_q.size() > 2) begin
         errors++;
         $display("FAIL read_ahead got %0d want <=2", out_q.size());
      end
      case (rdy_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
      drive_fifo();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_ready = 1'b0;
      drive_fifo();
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read got %b want 0", fifo_read); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
      if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %b want 0", m_last); end
      if (m_data !== '0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      if (bursts_done !== 16'd0) begin errors++; $display("FAIL rst_bursts got %0d want 0", bursts_done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_burst();
      int n_rd = 0, first_rd = 0, last_rd = 0, na = 0;
      int acc_t[8];
      logic [DW-1:0] acc_d[8];
      logic acc_l[8];
      logic [15:0] b0 = exp_bursts;
      rdy_mode = 1; m_ready = 1'b1;
      for (int i = 0; i < BL; i++) write_word(8'h10 + 8'(i), 1'b0);
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (obs_rd) begin
            n_rd++;
            if (first_rd == 0) first_rd = t;
            last_rd = t;
         end
         if (obs_acc && na < 8) begin
            acc_t[na] = t; acc_d[na] = obs_data; acc_l[na] = obs_last; na++;
         end
      end
      checks += 6;
      if (n_rd != 4) begin errors++; $display("FAIL sb_reads got %0d want 4", n_rd); end
      if (first_rd != 2) begin errors++; $display("FAIL sb_first_read got %0d want 2", first_rd); end
      if (last_rd - first_rd != 3) begin errors++; $display("FAIL sb_read_span got %0d want 3", last_rd - first_rd); end
      if (na != 4) begin errors++; $display("FAIL sb_accepts got %0d want 4", na); end
      if (bursts_done !== b0 + 16'd1) begin errors++; $display("FAIL sb_bursts got %0d want %0d", bursts_done, b0 + 16'd1); end
      if (na > 0 && acc_t[0] != first_rd + 1) begin errors++; $display("FAIL sb_latency got %0d want %0d", acc_t[0], first_rd + 1); end
      for (int i = 0; i < na && i < 4; i++) begin
         checks += 3;
         if (acc_d[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL sb_data got %h want %h", acc_d[i], 8'h10 + 8'(i)); end
         if (acc_l[i] !== (i == 3)) begin errors++; $display("FAIL sb_last got %b want %b", acc_l[i], i == 3); end
         if (acc_t[i] != acc_t[0] + i) begin errors++; $display("FAIL sb_consecutive got %0d want %0d", acc_t[i], acc_t[0] + i); end
      end
   endtask

`ifndef SCFIFO_DRAIN_FLUSH_EN
   task automatic test_partial_hold();
      int n_rd = 0, n_v = 0, na = 0, nl = 0;
      rdy_mode = 1; m_ready = 1'b1;
      for (int i = 0; i < 3; i++) write_word(8'h20 + 8'(i), 1'b0);
      for (int t = 0; t < 1000; t++) begin
         tick();
         if (obs_rd) n_rd++;
         if (obs_valid) n_v++;
      end
      checks += 2;
      if (n_rd != 0) begin errors++; $display("FAIL hold_reads got %0d want 0", n_rd); end
      if (n_v != 0) begin errors++; $display("FAIL hold_valid got %0d want 0", n_v); end
      write_word(8'h23, 1'b0);
      n_rd = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (obs_rd) n_rd++;
         if (obs_acc) begin na++; if (obs_last) nl++; end
      end
      checks += 3;
      if (n_rd != 4) begin errors++; $display("FAIL hold_burst_reads got %0d want 4", n_rd); end
      if (na != 4) begin errors++; $display("FAIL hold_burst_words got %0d want 4", na); end
      if (nl != 1) begin errors++; $display("FAIL hold_burst_lasts got %0d want 1", nl); end
   endtask
`else
   task automatic test_flush();
      int n_rd = 0, first_rd = 0, na = 0;
      logic [DW-1:0] ld = '0;
      logic [15:0] b0 = exp_bursts;
      rdy_mode = 1; m_ready = 1'b1;
      for (int i = 0; i < 3; i++) write_word(8'h20 + 8'(i), i == 2);
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (obs_rd) begin n_rd++; if (first_rd == 0) first_rd = t; end
         if (obs_acc) begin na++; if (obs_last) ld = obs_data; end
      end
      checks += 5;
      if (first_rd != TMO + 1) begin errors++; $display("FAIL flush_start got %0d want %0d", first_rd, TMO + 1); end
      if (n_rd != 3) begin errors++; $display("FAIL flush_reads got %0d want 3", n_rd); end
      if (na != 3) begin errors++; $display("FAIL flush_words got %0d want 3", na); end
      if (ld !== 8'h22) begin errors++; $display("FAIL flush_last got %h want 22", ld); end
      if (bursts_done !== b0 + 16'd1) begin errors++; $display("FAIL flush_bursts got %0d want %0d", bursts_done, b0 + 16'd1); end
   endtask
`endif

   task automatic test_backpressure();
      int n_rd = 0, na = 0;
      logic [DW-1:0] first_d = '0;
      rdy_mode = 0; m_ready = 1'b0;
      for (int i = 0; i < BL; i++) write_word(8'h30 + 8'(i), 1'b0);
      for (int t = 0; t < 10; t++) begin
         tick();
         if (obs_rd) n_rd++;
      end
      checks += 2;
      if (n_rd != 2) begin errors++; $display("FAIL bp_reads got %0d want 2", n_rd); end
      if (obs_rd !== 1'b0) begin errors++; $display("FAIL bp_read_stall got %b want 0", obs_rd); end
      rdy_mode = 1; m_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (obs_acc) begin if (na == 0) first_d = obs_data; na++; end
      end
      checks += 2;
      if (na != 4) begin errors++; $display("FAIL bp_words got %0d want 4", na); end
      if (first_d !== 8'h30) begin errors++; $display("FAIL bp_first got %h want 30", first_d); end
   endtask

   task automatic test_back_to_back();
      int n_rd = 0, run = 0, max_run = 0, nl = 0;
      logic [DW-1:0] l0 = '0, l1 = '0;
      logic [15:0] b0 = exp_bursts;
      rdy_mode = 1; m_ready = 1'b1;
      for (int i = 0; i < 2 * BL; i++) write_word(8'h40 + 8'(i), 1'b0);
      for (int t = 0; t < 30; t++) begin
         tick();
         if (obs_rd) begin n_rd++; run++; if (run > max_run) max_run = run; end
         else run = 0;
         if (obs_acc && obs_last) begin if (nl == 0) l0 = obs_data; else l1 = obs_data; nl++; end
      end
      checks += 6;
      if (n_rd != 8) begin errors++; $display("FAIL b2b_reads got %0d want 8", n_rd); end
      if (max_run != BL) begin errors++; $display("FAIL b2b_run got %0d want %0d", max_run, BL); end
      if (nl != 2) begin errors++; $display("FAIL b2b_lasts got %0d want 2", nl); end
      if (l0 !== 8'h43) begin errors++; $display("FAIL b2b_last0 got %h want 43", l0); end
      if (l1 !== 8'h47) begin errors++; $display("FAIL b2b_last1 got %h want 47", l1); end
      if (bursts_done !== b0 + 16'd2) begin errors++; $display("FAIL b2b_bursts got %0d want %0d", bursts_done, b0 + 16'd2); end
   endtask

   task automatic test_random();
      int n = 0;
      rdy_mode = 2;
      for (int t = 0; t < 1500; t++) begin
         if ($urandom_range(0, 7) == 0 && fifo_q.size() < 400)
            for (int k = 0; k < BL; k++) write_word(8'($urandom), 1'b0);
         tick();
      end
      rdy_mode = 1; m_ready = 1'b1;
      while ((fifo_q.size() != 0 || out_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (fifo_q.size() != 0 || out_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain got %0d words left want 0", fifo_q.size() + out_q.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int n_rd = 0, n_v = 0, na = 0;
      rdy_mode = 0; m_ready = 1'b0;
      for (int i = 0; i < BL; i++) write_word(8'h50 + 8'(i), 1'b0);
      for (int t = 0; t < 20 && n_rd < 2; t++) begin
         tick();
         if (obs_rd) n_rd++;
      end
      checks++;
      if (n_rd != 2) begin errors++; $display("FAIL rmb_reads got %0d want 2", n_rd); end
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (fifo_read !== 1'b0) begin errors++; $display("FAIL rmb_fifo_read got %b want 0", fifo_read); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rmb_m_valid got %b want 0", m_valid); end
      if ({m_last, m_data} !== '0) begin errors++; $display("FAIL rmb_head got %h want 0", {m_last, m_data}); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmb_busy got %b want 0", busy); end
      if (bursts_done !== 16'd0) begin errors++; $display("FAIL rmb_bursts got %0d want 0", bursts_done); end
      fifo_q.delete(); out_q.delete();
      exp_bursts = '0; wr_cnt = 0; hold_prev = 1'b0;
      drive_fifo();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rdy_mode = 1; m_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (obs_valid) n_v++;
      end
      checks++;
      if (n_v != 0) begin errors++; $display("FAIL rmb_stale got %0d want 0", n_v); end
      for (int i = 0; i < BL; i++) write_word(8'h60 + 8'(i), 1'b0);
      for (int t = 0; t < 20; t++) begin
         tick();
         if (obs_acc) na++;
      end
      checks += 2;
      if (na != 4) begin errors++; $display("FAIL rmb_after got %0d want 4", na); end
      if (bursts_done !== 16'd1) begin errors++; $display("FAIL rmb_after_bursts got %0d want 1", bursts_done); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
`ifndef SCFIFO_DRAIN_FLUSH_EN
      test_partial_hold();
`else
      test_flush();
`endif
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scfifo_burst_drain.md
Name: scfifo_burst_drain

Overview:
- Downstream consumer of the show-ahead single-clock FIFO. Drains FIFO words as fixed-length bursts onto a valid/ready stream with an end-of-burst marker.
- Waits until a whole burst is buffered before starting, so bursts leave back-to-back without bubbles.
- A 2-entry output buffer decouples m_ready from the FIFO read strobe, so there is no combinational ready-to-read path.

Parameters:
- DW, 8, data width; must equal the FIFO DW.
- AW, 10, FIFO address width; fifo_data_cnt is AW bits wide.
- BURST_LEN, 16, words per full burst. Legal range 1..2**AW-1; an out-of-range value is an elaboration error.
- TIMEOUT, 64, idle cycles before a partial flush. Used only with the optional feature. Range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- fifo_dout  in  DW  FIFO show-ahead data; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_data_cnt  in  AW  FIFO occupancy
- fifo_read  out  1  FIFO pop; the head word is consumed at this clock edge
- m_data  out  DW  stream data
- m_valid  out  1  stream valid
- m_last  out  1  last word of the burst; qualified by m_valid
- m_ready  in  1  downstream ready
- busy  out  1  high in state BURST
- bursts_done  out  16  count of bursts fully read from the FIFO; wraps at 65535 to 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, buffer occupancy occ=0, beat=0, blen=0, bursts_done=0, timer=0.
  - Outputs: fifo_read=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - Reset mid-burst discards buffered words; no partial m_last is produced afterwards.
- States: IDLE, BURST.
- IDLE -> BURST when fifo_data_cnt >= BURST_LEN.
  - Latch blen=BURST_LEN and beat=0.
  - The first fifo_read may assert in the cycle after the transition.
- fifo_read = (state==BURST) && !fifo_empty && (occ != 2).
  - Depends only on registered state and FIFO flags, never on m_ready.
  - Never asserts while fifo_empty=1. The FIFO has no underflow guard, so this is mandatory.
- Each read pushes {fifo_dout, last=(beat==blen-1)} into the buffer tail and increments beat.
  - On the last read, bursts_done increments and state returns to IDLE.
  - The IDLE start check is re-evaluated next cycle, so the minimum inter-burst gap is 1 cycle of fifo_read=0.
- Output buffer (2-entry FIFO):
  - m_data, m_valid and m_last are the head entry.
  - pop = m_valid && m_ready.
  - Push and pop in the same cycle keep occ unchanged and preserve order.
  - In steady state, with m_ready=1 held, the block sustains 1 word/cycle within a burst.
  - With m_ready=0, at most 2 words are read ahead; then fifo_read holds at 0.
- Latency: a word read at edge N has m_valid=1 after edge N if the buffer was empty.
- m_valid, once high, holds with m_data stable until accepted.
- Because a burst starts only when fifo_data_cnt >= blen, fifo_empty never stalls a full burst. The empty gating still applies, for safety.
- Concurrent FIFO writes during a burst are ignored by the burst logic; only the latched blen matters.

Optional Feature:
- Macro: SCFIFO_DRAIN_FLUSH_EN.
- With the macro defined:
  - In IDLE, timer increments each cycle while fifo_empty=0 and fifo_data_cnt < BURST_LEN.
  - timer clears when the FIFO is empty or on any IDLE->BURST transition.
  - When timer == TIMEOUT-1 and fifo_empty=0, go to BURST with blen = fifo_data_cnt, a partial burst whose last word carries m_last.
  - If the full-burst condition also holds that cycle, it wins: blen=BURST_LEN.
- Without the macro: no timer logic; words below BURST_LEN remain in the FIFO indefinitely. The TIMEOUT parameter is accepted and ignored.

Decomposition:
- Package scfifo_drain_pkg:
  - state enum drain_state_e {IDLE, BURST}.
  - Buffer entry struct {data, last}, parameterised by DW via a typedef in the module.
  - localparam BCNT_W=16.
- One sub-module: drain_out_buf. It is the 2-entry buffer with push/pop, occ output and head outputs, and is reusable as a skid stage.

Test Plan:
- BURST_LEN=4, preload 4 words 0x10..0x13, m_ready=1 -> fifo_read high 4 consecutive cycles; m_data 0x10..0x13 on consecutive cycles; m_last only on 0x13; bursts_done=1.
- Preload 3 words, flush disabled -> fifo_read stays 0 for 1000 cycles, m_valid=0. Write a 4th word -> one burst of 4.
- Burst of 4, m_ready=0 for 10 cycles then 1 -> exactly 2 reads, then fifo_read=0; after ready rises, all 4 words arrive in order with no loss or duplication.
- Preload 8 words, m_ready=1 -> two bursts; m_last on words 4 and 8; bursts_done=2; at least 1 idle cycle of fifo_read between bursts.
- SCFIFO_DRAIN_FLUSH_EN, TIMEOUT=8, preload 3 words -> flush burst starts after 8 idle cycles, 3 words out with m_last on the 3rd.
- Assert rst_n=0 after 2 words of a 4-word burst -> all outputs 0 immediately, occ=0, state IDLE, bursts_done=0.
